// File: rtl/iic_arb_pkg.sv
// Shared definitions for the IIC bus arbiter: FSM state encoding and parameter defaults.
package iic_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY
  } arb_state_e;

  localparam int unsigned ARB_NUM_REQ     = 3;
  localparam logic [23:0] ARB_TIMEOUT_CYC = 24'd1_485_000;

endpackage

// File: rtl/iic_bus_arbiter_if.sv
// Requester-side and IIC-master-side signal bundle of the IIC bus arbiter.
interface iic_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  // requester side
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ-1:0]   i_start;
  logic [NUM_REQ-1:0]   i_wr_rd_en;
  logic [NUM_REQ-1:0]   i_iic_main;
  logic [8*NUM_REQ-1:0] i_addr;
  logic [8*NUM_REQ-1:0] i_din;
  logic [NUM_REQ-1:0]   o_gnt;
  logic [NUM_REQ-1:0]   o_finish;
  logic                 o_no_ack;
  logic [NUM_REQ-1:0]   o_dout_en;
  logic [7:0]           o_dout;
  logic                 o_timeout;
  // IIC master side
  logic                 o_start;
  logic                 o_wr_rd_en;
  logic                 o_iic_main;
  logic [7:0]           o_addr;
  logic [7:0]           o_din;
  logic                 i_finish;
  logic                 i_no_ack;
  logic                 i_dout_en;
  logic [7:0]           i_dout;

  // arbiter view
  modport slave (
    input  i_req, i_start, i_wr_rd_en, i_iic_main, i_addr, i_din,
    input  i_finish, i_no_ack, i_dout_en, i_dout,
    output o_gnt, o_finish, o_no_ack, o_dout_en, o_dout, o_timeout,
    output o_start, o_wr_rd_en, o_iic_main, o_addr, o_din
  );

  // view of the surrounding logic driving the arbiter
  modport master (
    output i_req, i_start, i_wr_rd_en, i_iic_main, i_addr, i_din,
    output i_finish, i_no_ack, i_dout_en, i_dout,
    input  o_gnt, o_finish, o_no_ack, o_dout_en, o_dout, o_timeout,
    input  o_start, o_wr_rd_en, o_iic_main, o_addr, o_din
  );

endinterface

// File: rtl/iic_rr_picker.sv
// Combinational round-robin select: one-hot of the first set req bit at or after ptr, wrapping.
module iic_rr_picker #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt
);

  logic found;

  // upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1]
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k] && (k >= 32'(ptr))) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k] && (k < 32'(ptr))) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Round-robin arbiter sharing one IIC master among NUM_REQ requesters, grant held per burst.
// Optional BUSY watchdog enabled by defining IIC_ARB_TIMEOUT_EN.
module iic_bus_arbiter
  import iic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = ARB_NUM_REQ,
  parameter logic [23:0] TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
  input logic              i_clk,
  input logic              i_rst,
  iic_bus_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick_gnt;
  logic [PW-1:0]      ptr_q, ptr_d, g_idx;
  logic               start_q, start_d;
  logic               wr_rd_q, wr_rd_d;
  logic               main_q, main_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         din_q, din_d;
  logic [NUM_REQ-1:0] finish_q, finish_d;
  logic               no_ack_q, no_ack_d;
  logic [NUM_REQ-1:0] dout_en_q, dout_en_d;
  logic [7:0]         dout_q, dout_d;
  logic               timeout_q, timeout_d;
  logic               timeout_hit;
  logic [7:0]         sel_addr, sel_din;
  logic               sel_wr, sel_main;

  iic_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (bus.i_req),
    .ptr (ptr_q),
    .gnt (pick_gnt)
  );

`ifdef IIC_ARB_TIMEOUT_EN
  logic [23:0] to_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_BUSY) to_cnt_q <= '0;
    else                             to_cnt_q <= to_cnt_q + 24'd1;
  end

  assign timeout_hit = (state_q == ST_BUSY) && (to_cnt_q == TIMEOUT_CYC - 24'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // index and transaction fields of the current grantee
  always_comb begin
    g_idx    = '0;
    sel_addr = '0;
    sel_din  = '0;
    sel_wr   = 1'b0;
    sel_main = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        g_idx    = PW'(k);
        sel_addr = bus.i_addr[8*k +: 8];
        sel_din  = bus.i_din[8*k +: 8];
        sel_wr   = bus.i_wr_rd_en[k];
        sel_main = bus.i_iic_main[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    start_d   = 1'b0;
    wr_rd_d   = wr_rd_q;
    main_d    = main_q;
    addr_d    = addr_q;
    din_d     = din_q;
    finish_d  = '0;
    no_ack_d  = 1'b0;
    dout_en_d = '0;
    dout_d    = dout_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          gnt_d   = pick_gnt;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (|(bus.i_start & gnt_q)) begin
          start_d = 1'b1;
          wr_rd_d = sel_wr;
          main_d  = sel_main;
          addr_d  = sel_addr;
          din_d   = sel_din;
          state_d = ST_BUSY;
        end else if (!(|(bus.i_req & gnt_q))) begin
          gnt_d   = '0;
          ptr_d   = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.i_dout_en) begin
          dout_en_d = gnt_q;
          dout_d    = bus.i_dout;
        end
        if (bus.i_finish) begin
          finish_d = gnt_q;
          no_ack_d = bus.i_no_ack;
          state_d  = ST_GRANT;
        end else if (timeout_hit) begin
          finish_d  = gnt_q;
          no_ack_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_GRANT;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      start_q   <= 1'b0;
      wr_rd_q   <= 1'b0;
      main_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      finish_q  <= '0;
      no_ack_q  <= 1'b0;
      dout_en_q <= '0;
      dout_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      start_q   <= start_d;
      wr_rd_q   <= wr_rd_d;
      main_q    <= main_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      finish_q  <= finish_d;
      no_ack_q  <= no_ack_d;
      dout_en_q <= dout_en_d;
      dout_q    <= dout_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_start    = start_q;
  assign bus.o_wr_rd_en = wr_rd_q;
  assign bus.o_iic_main = main_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_din      = din_q;
  assign bus.o_finish   = finish_q;
  assign bus.o_no_ack   = no_ack_q;
  assign bus.o_dout_en  = dout_en_q;
  assign bus.o_dout     = dout_q;
  assign bus.o_timeout  = timeout_q;

endmodule
